comet_mem_arbiter: RTL and testbench

- Shares the single-port COMET II program/data RAM between two requesters: the CPU bus and a debug/loader port (program download, memory inspection).
- Drives the RAM write port (we/waddr/wdata, written on RAM's negedge mclk) and read port (re/raddr, combinational rdata).
- Arbitrates with CPU priority and a starvation guard for the debug port.
- Enforces the populated address window and returns registered read data with a one-cycle ack pulse.

---
 rtl/comet_mem_arbiter_if.sv | 28 ++
 rtl/comet_mem_arbiter.sv | 109 ++++++++++
 tb/tb_comet_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/comet_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// slave = arbiter view; master = environment view (requesters plus RAM).
interface comet_mem_arbiter_if;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_err, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_err, dbg_rdata,
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_err, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_err, dbg_rdata,
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/comet_mem_arbiter.sv
// COMET II RAM arbiter: CPU vs debug port, IDLE->ACCESS->RESP, one op per 3 cycles.
// COMET_MEM_ARB_RR_EN selects two-way round-robin instead of CPU priority + starvation guard.
module comet_mem_arbiter #(
  parameter logic [15:0] ADDR_LIMIT   = 16'h00FF,
  parameter int          STARVE_LIMIT = 4,
  parameter int          CNT_W        = 3
) (
  input logic                mclk,
  input logic                rst_n,
  comet_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        own_dbg, cmd_we, cmd_err;
  logic        any_req, grant, grant_dbg, sel_we, sel_err;
  logic [15:0] sel_addr, sel_wdata, rd_val;

  assign any_req = bus.cpu_req | bus.dbg_req;
  assign grant   = (state == IDLE) && any_req;

`ifdef COMET_MEM_ARB_RR_EN
  logic last_dbg;

  // Both requesting: serve whichever port was not served last.
  assign grant_dbg = bus.dbg_req && (!bus.cpu_req || !last_dbg);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)     last_dbg <= 1'b1;
    else if (grant) last_dbg <= grant_dbg;
  end
`else
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve;

  assign grant_dbg = bus.dbg_req && (!bus.cpu_req || starve >= STARVE_TH);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) starve <= '0;
    else if (state == IDLE) begin
      if (!bus.dbg_req || grant_dbg) starve <= '0;
      else if (starve != '1)         starve <= starve + CNT_W'(1);
    end
  end
`endif

  assign sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  assign sel_err   = sel_addr > ADDR_LIMIT;
  assign rd_val    = cmd_err ? 16'h0000 : bus.mem_rdata;

  always_comb begin
    state_nxt   = state;
    bus.mem_we  = 1'b0;
    bus.mem_re  = 1'b0;
    bus.cpu_ack = 1'b0;
    bus.cpu_err = 1'b0;
    bus.dbg_ack = 1'b0;
    bus.dbg_err = 1'b0;
    case (state)
      IDLE:   if (any_req) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt  = RESP;
        bus.mem_we = cmd_we && !cmd_err;
        bus.mem_re = !cmd_we && !cmd_err;
      end
      RESP: begin
        state_nxt   = IDLE;
        bus.cpu_ack = !own_dbg;
        bus.cpu_err = !own_dbg && cmd_err;
        bus.dbg_ack = own_dbg;
        bus.dbg_err = own_dbg && cmd_err;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem address/data registers double as the latched command and hold between ops.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      own_dbg       <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_err       <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_raddr <= '0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        own_dbg <= grant_dbg;
        cmd_we  <= sel_we;
        cmd_err <= sel_err;
        if (!sel_err && sel_we) begin
          bus.mem_waddr <= sel_addr;
          bus.mem_wdata <= sel_wdata;
        end
        if (!sel_err && !sel_we) bus.mem_raddr <= sel_addr;
      end
      if (state == ACCESS && !cmd_we) begin
        if (own_dbg) bus.dbg_rdata <= rd_val;
        else         bus.cpu_rdata <= rd_val;
      end
    end
  end
endmodule

// File: tb/tb_comet_mem_arbiter.sv
// Self-checking bench for comet_mem_arbiter: vector table, reset/contention/back-to-back
// sequences and random single ops checked against a word-array memory model.
module tb_comet_mem_arbiter;
  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  comet_mem_arbiter_if bus();
  comet_mem_arbiter #(.ADDR_LIMIT(16'h00FF), .STARVE_LIMIT(4), .CNT_W(3))
    dut (.mclk(mclk), .rst_n(rst_n), .bus(bus));

  localparam logic [15:0] LIM = 16'h00FF;
`ifdef COMET_MEM_ARB_RR_EN
  localparam int DBG_FIRST = 5, DBG_GAP = 6;
`else
  localparam int DBG_FIRST = 14, DBG_GAP = 15;
`endif

  int vec_n = 0;
  int mis_n = 0;

  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];
  bit          ram_init = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v[7:0], ~v[7:0]} ^ 16'h5A5A;
  endfunction

  // RAM model: writes on negedge, combinational read; junk when not enabled.
  always @(negedge mclk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (bus.mem_we) ram[bus.mem_waddr[7:0]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = bus.mem_re ? ram[bus.mem_raddr[7:0]] : 16'hDEAD;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit dbg, input bit req, input bit we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (dbg) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  // Single operation from IDLE; returns one cycle after the ack with the FSM back in IDLE.
  task automatic do_op(input string tag, input bit dbg, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd, input bit exp_err);
    int cyc, wes, res, oth;
    bit got, errv, inr;
    logic [15:0] oth_rd, rd;
    inr    = (addr <= LIM);
    oth_rd = dbg ? bus.cpu_rdata : bus.dbg_rdata;
    cyc = 0; wes = 0; res = 0; oth = 0; got = 0; errv = 0; rd = '0;
    drive(dbg, 1'b1, we, addr, wdata);
    while (!got && cyc < 8) begin
      @(posedge mclk); #1; cyc++;
      wes += int'(bus.mem_we);
      res += int'(bus.mem_re);
      if (dbg ? bus.cpu_ack : bus.dbg_ack) oth++;
      if (dbg ? bus.dbg_ack : bus.cpu_ack) begin
        got  = 1'b1;
        errv = dbg ? bus.dbg_err : bus.cpu_err;
        rd   = dbg ? bus.dbg_rdata : bus.cpu_rdata;
      end
    end
    drive(dbg, 1'b0, we, addr, wdata);
    chk({tag, " ack latency"}, got ? cyc : 99, 2);
    chk({tag, " err"}, errv, exp_err);
    if (!we) chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " mem_we cycles"}, wes, (we && inr) ? 1 : 0);
    chk({tag, " mem_re cycles"}, res, (!we && inr) ? 1 : 0);
    chk({tag, " other ack"}, oth, 0);
    chk({tag, " other rdata"}, dbg ? bus.cpu_rdata : bus.dbg_rdata, oth_rd);
    @(posedge mclk); #1;
    chk({tag, " ack pulse width"}, dbg ? bus.dbg_ack : bus.cpu_ack, 1'b0);
  endtask

  task automatic model_op(input string tag, input bit dbg, input bit we,
                          input logic [15:0] addr, input logic [15:0] wdata);
    bit inr;
    inr = (addr <= LIM);
    do_op(tag, dbg, we, addr, wdata, inr ? ref_mem[addr[7:0]] : 16'h0000, !inr);
    if (we && inr) ref_mem[addr[7:0]] = wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int n, cyc, last, k, lost, wes, ndbg;
    bit exp_d;
    logic [15:0] bb [6];
    bb = '{16'h1200, 16'h0000, 16'h1210, 16'h0001, 16'h1221, 16'h7FFE};
    tbl[0] = '{0, 1, 16'h0070, 16'h1234, 16'h0000, 0};
    tbl[1] = '{0, 0, 16'h0070, 16'h0000, 16'h1234, 0};
    tbl[2] = '{1, 0, 16'h0100, 16'h0000, 16'h0000, 1};
    tbl[3] = '{1, 1, 16'h8000, 16'hFFFF, 16'h0000, 1};
    tbl[4] = '{0, 1, 16'h00FF, 16'hBEEF, 16'h0000, 0};
    tbl[5] = '{1, 0, 16'h00FF, 16'h0000, 16'hBEEF, 0};
    tbl[6] = '{0, 0, 16'h0100, 16'h0000, 16'h0000, 1};
    tbl[7] = '{1, 1, 16'h0000, 16'h0F0F, 16'h0000, 0};
    tbl[8] = '{0, 0, 16'h0000, 16'h0000, 16'h0F0F, 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);

    // Reset state
    repeat (3) @(posedge mclk); #1;
    chk("reset flags", {bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err, bus.mem_we, bus.mem_re}, 0);
    chk("reset rdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
    chk("reset mem bus", {bus.mem_waddr, bus.mem_wdata}, 0);
    chk("reset mem raddr", bus.mem_raddr, 0);
    rst_n = 1'b1;
    @(posedge mclk); #1;

    // Reset in the middle of a CPU write's ACCESS cycle
    drive(0, 1, 1, 16'h0010, 16'hAAAA);
    @(posedge mclk); #1;
    chk("midrst access mem_we", bus.mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", {bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err, bus.mem_we, bus.mem_re}, 0);
    chk("midrst mem bus", {bus.mem_waddr, bus.mem_wdata}, 0);
    drive(0, 0, 1, 16'h0010, 16'hAAAA);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge mclk); #1;
      n += int'(bus.cpu_ack) + int'(bus.mem_we);
    end
    chk("midrst no ack/write", n, 0);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    chk("midrst ram[0x10] intact", ram[16], init_val(16));
    model_op("midrst reread", 0, 0, 16'h0010, 16'h0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].dbg, tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_rd, tbl[i].exp_err);
      if (tbl[i].we && tbl[i].addr <= LIM) ref_mem[tbl[i].addr[7:0]] = tbl[i].wdata;
    end

    // Back-to-back debug loads with req held high
    n = 0; cyc = 0; last = 0; wes = 0;
    drive(1, 1, 1, 16'h0000, bb[0]);
    while (n < 6 && cyc < 40) begin
      @(posedge mclk); #1; cyc++;
      wes += int'(bus.mem_we);
      if (bus.dbg_ack) begin
        chk("b2b ack spacing", cyc - last, (n == 0) ? 2 : 3);
        last = cyc;
        ref_mem[n] = bb[n];
        n++;
        if (n < 6) drive(1, 1, 1, 16'(n), bb[n]);
        else       drive(1, 0, 1, 16'(n - 1), bb[n - 1]);
      end
    end
    chk("b2b ack count", n, 6);
    chk("b2b write count", wes, 6);
    @(posedge mclk); #1;
    for (int i = 0; i < 6; i++) model_op($sformatf("b2b readback%0d", i), 1, 0, 16'(i), 16'h0);

    // Contention: both ports request reads continuously
    drive(0, 1, 0, 16'h0070, 16'h0);
    drive(1, 1, 0, 16'h0071, 16'h0);
    k = 0; lost = 0; ndbg = 0;
    for (int c = 1; c <= 44; c++) begin
      @(posedge mclk); #1;
      if (bus.cpu_ack || bus.dbg_ack) begin
`ifdef COMET_MEM_ARB_RR_EN
        exp_d = (k % 2 == 1);
`else
        exp_d = (lost >= 4);
        lost  = exp_d ? 0 : lost + 1;
`endif
        chk("contention single ack", bus.cpu_ack && bus.dbg_ack, 1'b0);
        chk("contention winner", bus.dbg_ack, exp_d);
        if (bus.dbg_ack) begin
          chk("contention dbg ack cycle", c, DBG_FIRST + DBG_GAP * ndbg);
          chk("contention dbg rdata", bus.dbg_rdata, ref_mem[16'h71]);
          ndbg++;
        end else chk("contention cpu rdata", bus.cpu_rdata, ref_mem[16'h70]);
        k++;
      end
    end
    drive(0, 0, 0, 16'h0070, 16'h0);
    drive(1, 0, 0, 16'h0071, 16'h0);
    chk("contention ack count", k, 15);
    @(posedge mclk); #1;

    // Random single operations against the memory model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'(16'h0100 + $urandom_range(0, 16'hFEFF))
                                      : 16'($urandom_range(0, 255));
      model_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               a, 16'($urandom));
    end

    // Whole-RAM comparison against the model
    for (int i = 0; i < 256; i++) chk($sformatf("ram[%0h]", i), ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
    $finish;
  end
endmodule
